// File: rtl/tx_channel_scheduler.sv
// Half-duplex TX start scheduler: carrier sense, slotted random backoff, bounded retries, RX mute.
// Optional TX watchdog is enabled by defining TX_SCHED_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | no frame pending
// SENSE   | counting consecutive idle slots (DIFS)
// BACKOFF | counting down random backoff slots
// START   | one-cycle start pulse to the symbol generator
// TX      | frame on air, waiting for tx_done
// GUARD   | post-TX receiver mute interval
// DROP    | one-cycle drop after retries exhausted
module tx_channel_scheduler #(
    parameter int unsigned SLOT_CYCLES  = 1920,
    parameter int unsigned DIFS_SLOTS   = 4,
    parameter int unsigned CW_MIN_LOG2  = 3,
    parameter int unsigned CW_MAX_LOG2  = 8,
    parameter int unsigned MAX_RETRY    = 4,
    parameter int unsigned GUARD_CYCLES = 960,
    parameter int unsigned TX_TIMEOUT   = 4_000_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frame_req,
    input  logic                             channel_busy,
    input  logic                             tx_done,
    output logic                             tx_start,
    output logic                             tx_active,
    output logic                             rx_mute,
    output logic                             frame_drop,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic [2:0]                       state_o
);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam int unsigned SW = $clog2(SLOT_CYCLES + 1);
    localparam int unsigned DW = $clog2(DIFS_SLOTS + 1);
    localparam int unsigned BW = CW_MAX_LOG2;
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SENSE   = 3'd1,
        BACKOFF = 3'd2,
        START   = 3'd3,
        TX      = 3'd4,
        GUARD   = 3'd5,
        DROP    = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [DW-1:0]  idle_q, idle_d;
    logic [BW-1:0]  bo_q, bo_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic           drop_d;
    logic           tx_start_q, tx_active_q, rx_mute_q, frame_drop_q;

`ifdef TX_SCHED_WATCHDOG_EN
    localparam int unsigned TW = $clog2(TX_TIMEOUT + 1);
    logic [TW-1:0]  wd_q, wd_d;
`endif

    logic           slot_end;
    int unsigned    cw_exp;
    logic [31:0]    draw_mask;
    logic [BW-1:0]  bo_draw;

    assign slot_end = (slot_q == '0);

    // Window exponent follows the retry count held before this busy event.
    always_comb begin
        cw_exp = CW_MIN_LOG2 + 32'(retry_q);
        if (cw_exp > CW_MAX_LOG2) cw_exp = CW_MAX_LOG2;
        draw_mask = (32'd1 << cw_exp) - 32'd1;
        bo_draw   = BW'({16'h0, lfsr_q} & draw_mask);
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        idle_d  = idle_q;
        bo_d    = bo_q;
        retry_d = retry_q;
        guard_d = guard_q;
        drop_d  = 1'b0;
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        case (state_q)
            IDLE: if (frame_req) state_d = SENSE;
            SENSE: begin
                if (!frame_req) begin
                    retry_d = '0;
                    state_d = IDLE;
                end else if (channel_busy) begin
                    idle_d = '0;
                    if (retry_q == RW'(MAX_RETRY)) begin
                        drop_d  = 1'b1;
                        retry_d = '0;
                        state_d = DROP;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        bo_d    = bo_draw;
                        state_d = BACKOFF;
                    end
                end else if (slot_end) begin
                    if (idle_q == DW'(DIFS_SLOTS - 1)) begin
                        state_d = (bo_q == '0) ? START : BACKOFF;
                    end else begin
                        idle_d = idle_q + DW'(1);
                    end
                end
            end
            BACKOFF: begin
                if (!frame_req) begin
                    retry_d = '0;
                    state_d = IDLE;
                end else if (channel_busy || bo_q == '0) begin
                    state_d = SENSE;
                end else if (slot_end) begin
                    bo_d = bo_q - BW'(1);
                    if (bo_q == BW'(1)) state_d = SENSE;
                end
            end
            START: state_d = TX;
            TX: begin
                if (tx_done) begin
                    retry_d = '0;
                    guard_d = GW'(GUARD_CYCLES);
                    state_d = GUARD;
                end
`ifdef TX_SCHED_WATCHDOG_EN
                else if (wd_q == '0) begin
                    drop_d  = 1'b1;
                    retry_d = '0;
                    guard_d = GW'(GUARD_CYCLES);
                    state_d = GUARD;
                end
`endif
            end
            GUARD: begin
                if (guard_q <= GW'(1)) begin
                    guard_d = '0;
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q - GW'(1);
                end
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            slot_d = SW'(SLOT_CYCLES - 1);
        end else if (state_q == SENSE || state_q == BACKOFF) begin
            slot_d = slot_end ? SW'(SLOT_CYCLES - 1) : slot_q - SW'(1);
        end
        if (state_d == SENSE && state_q != SENSE) idle_d = '0;

`ifdef TX_SCHED_WATCHDOG_EN
        wd_d = wd_q;
        if (state_q == START) wd_d = TW'(TX_TIMEOUT - 1);
        else if (state_q == TX && wd_q != '0) wd_d = wd_q - TW'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            idle_q       <= '0;
            bo_q         <= '0;
            retry_q      <= '0;
            guard_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            tx_start_q   <= 1'b0;
            tx_active_q  <= 1'b0;
            rx_mute_q    <= 1'b0;
            frame_drop_q <= 1'b0;
`ifdef TX_SCHED_WATCHDOG_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            idle_q       <= idle_d;
            bo_q         <= bo_d;
            retry_q      <= retry_d;
            guard_q      <= guard_d;
            lfsr_q       <= lfsr_d;
            tx_start_q   <= (state_d == START);
            tx_active_q  <= (state_d == TX);
            rx_mute_q    <= (state_d == TX) || (state_d == GUARD);
            frame_drop_q <= drop_d;
`ifdef TX_SCHED_WATCHDOG_EN
            wd_q         <= wd_d;
`endif
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_active  = tx_active_q;
    assign rx_mute    = rx_mute_q;
    assign frame_drop = frame_drop_q;
    assign retry_cnt  = retry_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_tx_channel_scheduler.sv
// Self-checking bench for tx_channel_scheduler with small timing parameters.
module tb_tx_channel_scheduler;
    localparam int SLOT  = 4;
    localparam int DIFS  = 2;
    localparam int GRD   = 3;
    localparam int MAXR  = 2;
    localparam int CWMIN = 1;
    localparam int CWMAX = 8;
    localparam int TOUT  = 20;
    localparam logic [15:0] SEED = 16'h0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_req = 1'b0;
    logic channel_busy = 1'b0;
    logic tx_done = 1'b0;
    logic tx_start, tx_active, rx_mute, frame_drop;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    tx_channel_scheduler #(
        .SLOT_CYCLES(SLOT), .DIFS_SLOTS(DIFS), .CW_MIN_LOG2(CWMIN), .CW_MAX_LOG2(CWMAX),
        .MAX_RETRY(MAXR), .GUARD_CYCLES(GRD), .TX_TIMEOUT(TOUT), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .channel_busy(channel_busy),
        .tx_done(tx_done), .tx_start(tx_start), .tx_active(tx_active), .rx_mute(rx_mute),
        .frame_drop(frame_drop), .retry_cnt(retry_cnt), .state_o(state_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_req = 1'b0; channel_busy = 1'b0; tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // Reference LFSR: value held during cycle n after reset release.
    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] v;
        v = SEED;
        for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
    endfunction

    // Expected tx_start cycle: one DIFS after SENSE entry, or after a single busy hit in SENSE
    // (retry 0 -> window 2^CWMIN), backoff slots then a fresh DIFS.
    function automatic int predict_start(input int req_at, input int busy_at);
        logic [15:0] l;
        int draw, bo_time;
        if (busy_at < 0) return req_at + 1 + DIFS * SLOT;
        l = lfsr_at(busy_at);
        draw = int'(l) % (1 << CWMIN);
        bo_time = (draw == 0) ? 1 : draw * SLOT;
        return busy_at + 1 + bo_time + DIFS * SLOT;
    endfunction

    function automatic int find_req_draw1();
        logic [15:0] l;
        for (int r = 0; r < 500; r++) begin
            l = lfsr_at(r + 1);
            if (l[0]) return r;
        end
        return 0;
    endfunction

    int ob_start, ob_nstart, ob_mute_first, ob_mute_last, ob_act_last, ob_ndrop;
    int ob_retry_bo, ob_retry_after, ob_td;

    task automatic run_trial(input int req_at, input int busy_at, input int d, input int extra);
        bit done_sent;
        int td_l;
        done_sent = 0; td_l = -1;
        ob_start = -1; ob_nstart = 0; ob_mute_first = -1; ob_mute_last = -1;
        ob_act_last = -1; ob_ndrop = 0; ob_retry_bo = -1; ob_retry_after = -1;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (tx_start) begin ob_nstart++; if (ob_start < 0) ob_start = c; end
            if (rx_mute) begin if (ob_mute_first < 0) ob_mute_first = c; ob_mute_last = c; end
            if (tx_active) ob_act_last = c;
            if (frame_drop) ob_ndrop++;
            if (busy_at >= 0 && c == busy_at + 2) ob_retry_bo = int'(retry_cnt);
            if (td_l >= 0 && c == td_l + 1) ob_retry_after = int'(retry_cnt);
            channel_busy = (c == busy_at);
            tx_done = 1'b0;
            if (ob_start >= 0 && c == ob_start + d) begin tx_done = 1'b1; td_l = c; done_sent = 1; end
            if (extra == 1 && ob_start >= 0 && c == ob_start) tx_done = 1'b1;
            if (extra == 2 && td_l >= 0 && c == td_l + 2) tx_done = 1'b1;
            frame_req = (c >= req_at) && !done_sent;
            if (td_l >= 0 && c > td_l + GRD + 3) break;
            tick();
        end
        ob_td = td_l;
        tx_done = 1'b0; channel_busy = 1'b0; frame_req = 1'b0;
    endtask

    typedef struct {
        int req_at;
        int d;
        int extra;
        int exp_start;
        int exp_mute_last;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int r, b, k, d, ex, exp_s, st_a, st_b, ret_a, ret_b, start_c;
        int n_start, n_drop, drop_c, ret_drop, st_after, ret_mid, act_first, act_last, mute_last;
        bit seen;

        vecs[0] = '{0, 1, 0, 9, 13};
        vecs[1] = '{3, 4, 1, 12, 19};
        vecs[2] = '{7, 2, 2, 16, 21};
        vecs[3] = '{20, 6, 0, 29, 38};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_active", 32'(tx_active), 0);
        check("rst_rx_mute", 32'(rx_mute), 0);
        check("rst_frame_drop", 32'(frame_drop), 0);
        check("rst_retry", 32'(retry_cnt), 0);
        check("rst_state", 32'(state_o), 0);

        // Idle-channel vectors
        for (int i = 0; i < 4; i++) begin
            run_trial(vecs[i].req_at, -1, vecs[i].d, vecs[i].extra);
            check($sformatf("vec%0d_start_cycle", i), ob_start, vecs[i].exp_start);
            check($sformatf("vec%0d_start_count", i), ob_nstart, 1);
            check($sformatf("vec%0d_mute_first", i), ob_mute_first, vecs[i].exp_start + 1);
            check($sformatf("vec%0d_mute_last", i), ob_mute_last, vecs[i].exp_mute_last);
            check($sformatf("vec%0d_end_state", i), 32'(state_o), 0);
        end

        // Randomized single busy hit during the first DIFS
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 30);
            k = $urandom_range(1, DIFS * SLOT);
            d = $urandom_range(1, 6);
            ex = $urandom_range(0, 2);
            b = r + k;
            exp_s = predict_start(r, b);
            run_trial(r, b, d, ex);
            check($sformatf("rnd%0d_start_cycle", i), ob_start, exp_s);
            check($sformatf("rnd%0d_start_count", i), ob_nstart, 1);
            check($sformatf("rnd%0d_retry_backoff", i), ob_retry_bo, 1);
            check($sformatf("rnd%0d_retry_after_done", i), ob_retry_after, 0);
            check($sformatf("rnd%0d_mute_first", i), ob_mute_first, exp_s + 1);
            check($sformatf("rnd%0d_active_last", i), ob_act_last, ob_td);
            check($sformatf("rnd%0d_mute_last", i), ob_mute_last, ob_td + GRD);
            check($sformatf("rnd%0d_no_drop", i), ob_ndrop, 0);
        end

        // Persistent busy: third busy-sense drops the frame
        do_reset();
        n_start = 0; n_drop = 0; drop_c = -1; ret_drop = -1; st_after = -1; ret_mid = -1;
        for (int c = 0; c < 30; c++) begin
            if (tx_start) n_start++;
            if (drop_c >= 0 && c == drop_c + 1) st_after = int'(state_o);
            if (frame_drop) begin n_drop++; drop_c = c; ret_drop = int'(retry_cnt); end
            if (c == 5) ret_mid = int'(retry_cnt);
            channel_busy = (c >= 2);
            frame_req = (n_drop == 0);
            tick();
        end
        channel_busy = 1'b0; frame_req = 1'b0;
        check("drop_pulse_count", n_drop, 1);
        check("drop_cycle", drop_c, 7);
        check("drop_retry_before", ret_mid, 2);
        check("drop_retry_cleared", ret_drop, 0);
        check("drop_then_idle", st_after, 0);
        check("drop_no_start", n_start, 0);

        // Busy inside BACKOFF with counter 1: freeze, back to SENSE, no retry increment
        r = find_req_draw1();
        b = r + 1;
        do_reset();
        st_a = -1; st_b = -1; ret_a = -1; ret_b = -1; start_c = -1; seen = 0;
        for (int c = 0; c < b + 40; c++) begin
            if (c == b + 3) begin st_a = int'(state_o); ret_a = int'(retry_cnt); end
            if (c == b + 11) begin st_b = int'(state_o); ret_b = int'(retry_cnt); end
            if (tx_start && start_c < 0) start_c = c;
            channel_busy = (c == b) || (c == b + 2);
            tx_done = (start_c >= 0 && c == start_c + 2);
            if (tx_done) seen = 1;
            frame_req = (c >= r) && !seen;
            tick();
        end
        tx_done = 1'b0; channel_busy = 1'b0; frame_req = 1'b0;
        check("freeze_back_to_sense", st_a, 1);
        check("freeze_retry_held", ret_a, 1);
        check("freeze_resume_backoff", st_b, 2);
        check("freeze_retry_no_inc", ret_b, 1);
        check("freeze_start_cycle", start_c, b + 23);

        // frame_req withdrawn in BACKOFF
        do_reset();
        st_a = -1; ret_a = -1; st_b = -1; ret_b = -1; n_start = 0;
        for (int c = 0; c < b + 25; c++) begin
            if (c == b + 2) begin st_a = int'(state_o); ret_a = int'(retry_cnt); end
            if (c == b + 3) begin st_b = int'(state_o); ret_b = int'(retry_cnt); end
            if (tx_start) n_start++;
            channel_busy = (c == b);
            frame_req = (c >= r) && (c < b + 2);
            tick();
        end
        channel_busy = 1'b0;
        check("cancel_in_backoff", st_a, 2);
        check("cancel_retry_before", ret_a, 1);
        check("cancel_idle_next", st_b, 0);
        check("cancel_retry_cleared", ret_b, 0);
        check("cancel_no_start", n_start, 0);

        // Long TX then async reset mid-TX
        do_reset();
        frame_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (tx_active) seen = 1;
            else tick();
        end
        check("midtx_reached_tx", 32'(tx_active), 1);
`ifndef TX_SCHED_WATCHDOG_EN
        n_drop = 0;
        for (int c = 0; c < TOUT + 5; c++) begin
            if (frame_drop) n_drop++;
            tick();
        end
        check("tx_waits_no_drop", n_drop, 0);
        check("tx_waits_active", 32'(tx_active), 1);
`else
        repeat (3) tick();
`endif
        rst_n = 1'b0;
        #1;
        check("midtx_rst_active", 32'(tx_active), 0);
        check("midtx_rst_mute", 32'(rx_mute), 0);
        check("midtx_rst_start", 32'(tx_start), 0);
        check("midtx_rst_state", 32'(state_o), 0);
        frame_req = 1'b0;

`ifdef TX_SCHED_WATCHDOG_EN
        do_reset();
        act_first = -1; act_last = -1; mute_last = -1; drop_c = -1; n_drop = 0; st_after = -1;
        for (int c = 0; c < 60; c++) begin
            if (tx_active) begin if (act_first < 0) act_first = c; act_last = c; end
            if (rx_mute) mute_last = c;
            if (drop_c >= 0 && c == drop_c + GRD) st_after = int'(state_o);
            if (frame_drop) begin n_drop++; drop_c = c; end
            frame_req = (n_drop == 0);
            tick();
        end
        frame_req = 1'b0;
        check("wd_active_first", act_first, 10);
        check("wd_drop_cycle", drop_c, act_first + TOUT);
        check("wd_drop_count", n_drop, 1);
        check("wd_active_last", act_last, act_first + TOUT - 1);
        check("wd_mute_last", mute_last, act_first + TOUT + GRD - 1);
        check("wd_idle_after_guard", st_after, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule
